// File: rtl/fibo_scroll_ctrl.sv
// fibo_scroll_ctrl: fills an external SRAM with a Fibonacci table, then
// periodically reads one table line and publishes it as a two-line
// scrolling display update. A button press reverses the scroll direction.
module fibo_scroll_ctrl #(
  parameter int N_ENTRIES = 25,  // table entries, 2..32
  parameter int DATA_W    = 16,  // stored value width
  parameter int TICK_BITS = 25   // display update period is 2^TICK_BITS cycles (>= 3)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_pressed,
  output logic              sram_en,
  output logic              sram_we,
  output logic [4:0]        sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              fill_done,
  output logic              scroll_dir,
  output logic              upd_valid,
  output logic              upd_dir,
  output logic [4:0]        upd_index,
  output logic [DATA_W-1:0] upd_value
);

  localparam logic [4:0] LAST_ADDR = 5'(N_ENTRIES - 1);
  localparam logic [5:0] FILL_END  = 6'(N_ENTRIES);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_IDLE    = 2'd1,
    S_READ    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Registered outputs and their next values
  logic              r_sram_en,    w_sram_en_next;
  logic              r_sram_we,    w_sram_we_next;
  logic [4:0]        r_sram_addr,  w_sram_addr_next;
  logic [DATA_W-1:0] r_sram_wdata, w_sram_wdata_next;
  logic              r_fill_done,  w_fill_done_next;
  logic              r_upd_valid,  w_upd_valid_next;
  logic              r_upd_dir,    w_upd_dir_next;
  logic [4:0]        r_upd_index,  w_upd_index_next;
  logic [DATA_W-1:0] r_upd_value,  w_upd_value_next;

  // Internal datapath state
  logic [5:0]        r_fill_cnt,   w_fill_cnt_next;
  logic [DATA_W-1:0] r_fib_a,      w_fib_a_next;   // value written two steps ago
  logic [DATA_W-1:0] r_fib_b,      w_fib_b_next;   // value written one step ago
  logic [4:0]        r_top,        w_top_next;     // address of the upper display line
  logic              r_rd_dir,     w_rd_dir_next;  // direction latched with the read
  logic              r_scroll_dir;
  logic [TICK_BITS-1:0] r_tick_cnt;
  logic              r_tick;

  // Combinational helpers
  logic [DATA_W-1:0] w_fib_wdata;
  logic [4:0]        w_top_inc;
  logic [4:0]        w_lower_inc;
  logic [4:0]        w_top_dec;
  logic [4:0]        w_rd_addr;
  logic [4:0]        w_top_step;

  // First two entries are seeds; the rest are the running sum (wraps at DATA_W)
  assign w_fib_wdata = (r_fill_cnt == 6'd0) ? '0 :
                       (r_fill_cnt == 6'd1) ? DATA_W'(1) :
                       r_fib_a + r_fib_b;

  // Modulo-N neighbours of the window; N need not be a power of two
  assign w_top_inc   = (r_top == LAST_ADDR) ? 5'd0 : r_top + 5'd1;
  assign w_lower_inc = (w_top_inc == LAST_ADDR) ? 5'd0 : w_top_inc + 5'd1;
  assign w_top_dec   = (r_top == 5'd0) ? LAST_ADDR : r_top - 5'd1;

  // Scrolling up fetches the line just below the window, scrolling down
  // fetches the line just above it; either way the window slides one step.
  assign w_rd_addr  = r_scroll_dir ? w_top_dec : w_lower_inc;
  assign w_top_step = r_scroll_dir ? w_top_dec : w_top_inc;

  // Tick timebase: free-running once the table is full. The tick is
  // registered so the FSM sees a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (r_fill_done) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_tick <= (r_tick_cnt == {TICK_BITS{1'b1}});
    end
  end

  // Scroll direction toggles on every press, independent of FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scroll_dir <= 1'b0;
    end else if (btn_pressed) begin
      r_scroll_dir <= ~r_scroll_dir;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:    if (r_fill_cnt == FILL_END) w_state_next = S_IDLE;
      S_IDLE:    if (r_tick) w_state_next = S_READ;
      S_READ:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_IDLE;
      default:   w_state_next = S_FILL;
    endcase
  end

  // FSM output logic: next values for SRAM port, window and update registers
  always_comb begin
    w_sram_en_next    = 1'b0;
    w_sram_we_next    = 1'b0;
    w_sram_addr_next  = r_sram_addr;
    w_sram_wdata_next = r_sram_wdata;
    w_fill_done_next  = r_fill_done;
    w_fill_cnt_next   = r_fill_cnt;
    w_fib_a_next      = r_fib_a;
    w_fib_b_next      = r_fib_b;
    w_top_next        = r_top;
    w_rd_dir_next     = r_rd_dir;
    w_upd_valid_next  = 1'b0;
    w_upd_dir_next    = r_upd_dir;
    w_upd_index_next  = r_upd_index;
    w_upd_value_next  = r_upd_value;
    case (r_state)
      S_FILL: begin
        if (r_fill_cnt != FILL_END) begin
          w_sram_en_next    = 1'b1;
          w_sram_we_next    = 1'b1;
          w_sram_addr_next  = r_fill_cnt[4:0];
          w_sram_wdata_next = w_fib_wdata;
          w_fib_a_next      = r_fib_b;
          w_fib_b_next      = w_fib_wdata;
          w_fill_cnt_next   = r_fill_cnt + 6'd1;
        end else begin
          w_fill_done_next  = 1'b1;
        end
      end
      S_IDLE: begin
        if (r_tick) begin
          // Direction is sampled here, before any same-cycle toggle lands
          w_sram_en_next   = 1'b1;
          w_sram_we_next   = 1'b0;
          w_sram_addr_next = w_rd_addr;
          w_top_next       = w_top_step;
          w_rd_dir_next    = r_scroll_dir;
        end
      end
      S_READ: begin
        // Read is on the bus this cycle; data returns next cycle
      end
      S_CAPTURE: begin
        w_upd_valid_next = 1'b1;
        w_upd_dir_next   = r_rd_dir;
        w_upd_index_next = r_sram_addr + 5'd1;
        w_upd_value_next = sram_rdata;
      end
      default: begin
      end
    endcase
  end

  // Register bank for everything the output logic computes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sram_en    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_fill_done  <= 1'b0;
      r_fill_cnt   <= '0;
      r_fib_a      <= '0;
      r_fib_b      <= '0;
      r_top        <= '0;
      r_rd_dir     <= 1'b0;
      r_upd_valid  <= 1'b0;
      r_upd_dir    <= 1'b0;
      r_upd_index  <= '0;
      r_upd_value  <= '0;
    end else begin
      r_sram_en    <= w_sram_en_next;
      r_sram_we    <= w_sram_we_next;
      r_sram_addr  <= w_sram_addr_next;
      r_sram_wdata <= w_sram_wdata_next;
      r_fill_done  <= w_fill_done_next;
      r_fill_cnt   <= w_fill_cnt_next;
      r_fib_a      <= w_fib_a_next;
      r_fib_b      <= w_fib_b_next;
      r_top        <= w_top_next;
      r_rd_dir     <= w_rd_dir_next;
      r_upd_valid  <= w_upd_valid_next;
      r_upd_dir    <= w_upd_dir_next;
      r_upd_index  <= w_upd_index_next;
      r_upd_value  <= w_upd_value_next;
    end
  end

  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign fill_done  = r_fill_done;
  assign scroll_dir = r_scroll_dir;
  assign upd_valid  = r_upd_valid;
  assign upd_dir    = r_upd_dir;
  assign upd_index  = r_upd_index;
  assign upd_value  = r_upd_value;

endmodule

// File: tb/tb_fibo_scroll_ctrl.sv
// Testbench for fibo_scroll_ctrl: SRAM model plus a cycle-level reference
// model of fill, tick timing, window movement and direction toggling.
module tb_fibo_scroll_ctrl;
  localparam int N    = 25;
  localparam int DW   = 16;
  localparam int TB   = 4;
  localparam int PER  = 1 << TB;
  localparam int MAXP = 1500;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_pressed;
  logic          sram_en, sram_we;
  logic [4:0]    sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          fill_done, scroll_dir, upd_valid, upd_dir;
  logic [4:0]    upd_index;
  logic [DW-1:0] upd_value;

  always #5 clk = ~clk;

  fibo_scroll_ctrl #(.N_ENTRIES(N), .DATA_W(DW), .TICK_BITS(TB)) dut (
    .clk(clk), .reset(reset), .btn_pressed(btn_pressed),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .fill_done(fill_done), .scroll_dir(scroll_dir),
    .upd_valid(upd_valid), .upd_dir(upd_dir),
    .upd_index(upd_index), .upd_value(upd_value)
  );

  // Synchronous SRAM: read data valid the cycle after the read
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int fib_tab [N];

  // Expected events, indexed by period number within a session
  int exp_rd  [MAXP];
  bit exp_uv  [MAXP];
  int exp_ui  [MAXP];
  int exp_val [MAXP];
  bit exp_ud  [MAXP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One session from reset release: fill, then n_ticks display updates.
  // With abort set, reset is raised during the read of the last tick.
  task automatic run_session(input int n_ticks, input bit abort);
    int  top = 0;
    bit  dir = 1'b0;
    int  f   = N + 1;              // first period with fill_done high
    int  t1  = f + PER;            // first tick period
    int  last_t = t1 + PER * (n_ticks - 1);
    int  p_end  = abort ? last_t + 1 : last_t + 4;
    int  k, rd;
    bit  b;
    for (int i = 0; i < MAXP; i++) begin
      exp_rd[i] = -1; exp_uv[i] = 1'b0; exp_ui[i] = 0; exp_val[i] = 0; exp_ud[i] = 1'b0;
    end
    for (int p = 1; p <= p_end; p++) begin
      @(posedge clk);
      @(negedge clk);
      k = 0;
      if (p >= t1 && ((p - t1) % PER) == 0) begin
        k = (p - t1) / PER + 1;
        if (dir == 1'b0) begin
          rd  = (top + 2) % N;
          top = (top + 1) % N;
        end else begin
          rd  = (top + N - 1) % N;
          top = (top + N - 1) % N;
        end
        exp_rd[p + 1]  = rd;
        exp_uv[p + 3]  = 1'b1;
        exp_ui[p + 3]  = rd + 1;
        exp_val[p + 3] = fib_tab[rd];
        exp_ud[p + 3]  = dir;
      end
      if (p <= N) begin
        check($sformatf("fill_wr p=%0d", p), {sram_en, sram_we, sram_addr, sram_wdata},
              {1'b1, 1'b1, 5'(p - 1), 16'(fib_tab[p - 1])});
        if (p == N) $display("fill complete: last write addr=%0d data=0x%0h", sram_addr, sram_wdata);
      end else if (exp_rd[p] >= 0) begin
        check($sformatf("read p=%0d", p), {sram_en, sram_we, sram_addr}, {1'b1, 1'b0, 5'(exp_rd[p])});
      end else begin
        check($sformatf("sram_quiet p=%0d", p), {sram_en, sram_we}, 2'b00);
      end
      check($sformatf("fill_done p=%0d", p), fill_done, (p > N));
      check($sformatf("scroll_dir p=%0d", p), scroll_dir, dir);
      check($sformatf("upd_valid p=%0d", p), upd_valid, exp_uv[p]);
      if (exp_uv[p]) begin
        $display("update p=%0d dir=%0d index=%0d value=%0d", p, upd_dir, upd_index, upd_value);
        check($sformatf("upd_index p=%0d", p), upd_index, exp_ui[p]);
        check($sformatf("upd_value p=%0d", p), upd_value, exp_val[p]);
        check($sformatf("upd_dir p=%0d", p), upd_dir, exp_ud[p]);
      end
      // Stimulus: two presses during fill, one press after the up-wrap,
      // one press coinciding with a tick, then random presses.
      b = 1'b0;
      if (p == 5 || p == 9) b = 1'b1;
      if (n_ticks >= 32) begin
        if (p == t1 + PER * 24 + 5) b = 1'b1;
        if (k == 30) b = 1'b1;
        if (p > t1 + PER * 31 && $urandom_range(0, 19) == 0) b = 1'b1;
      end
      btn_pressed = b;
      if (b) dir = ~dir;
      if (abort && p == last_t + 1) reset = 1'b1;
    end
    btn_pressed = 1'b0;
  endtask

  initial begin
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i < N; i++) fib_tab[i] = (fib_tab[i - 1] + fib_tab[i - 2]) & 16'hFFFF;

    reset = 1'b1;
    btn_pressed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst sram", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
    check("rst flags", {fill_done, scroll_dir, upd_valid, upd_dir}, 0);
    check("rst upd", {upd_index, upd_value}, 0);
    reset = 1'b0;

    run_session(64, 1'b1);

    // Reset lands while the last read is in flight: no update may appear
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("abort upd_valid c=%0d", c), upd_valid, 1'b0);
      check($sformatf("abort sram c=%0d", c), {sram_en, sram_we, sram_addr}, 0);
      check($sformatf("abort flags c=%0d", c), {fill_done, scroll_dir}, 0);
      if (c == 3) reset = 1'b0;
    end
    $display("reset during read applied; restarting fill");

    run_session(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
